accel_job_sequencer: RTL
========================

# accel_job_sequencer

Sequences the memory-to-memory accelerator run configured through the Avalon slave register file. On a GO edge it performs NUM jobs of SIZE 32-bit words each. For every word it reads from the source buffer through an Avalon-MM master, passes the word through the compute datapath via valid/ready, and writes the result to the destination buffer. It reports completion on DONE, which feeds back into status bit 31 of register 0.

## Interface
- No parameters; data width is fixed at 32 and the address width at 32.
- CSI_CLOCK_CLK  in  1  system clock; all logic is on the rising edge.
- CSI_CLOCK_RESET  in  1  synchronous, active-high reset.
- START  in  1  GO level from register 0 bit 0.
- SIZE  in  19  words per job.
- NUM  in  11  number of jobs.
- SRC_BASE  in  32  source byte address, from register 1.
- DST_BASE  in  32  destination byte address, from register 2.
- DONE  out  1  run complete; feeds the slave DONE input.
- BUSY  out  1  run in progress.
- JOB_IDX  out  11  index of the current job, 0-based.
- AVM_ADDRESS  out  32  master byte address.
- AVM_READ / AVM_WRITE  out  1  master read and write strobes.
- AVM_WRITEDATA  out  32  write data.
- AVM_WAITREQUEST  in  1  slave stall.
- AVM_READDATA  in  32  read data.
- AVM_READDATAVALID  in  1  read data valid.
- DP_IN_DATA  out  32, DP_IN_VALID  out  1, DP_IN_READY  in  1  operand stream to the datapath.
- DP_OUT_DATA  in  32, DP_OUT_VALID  in  1, DP_OUT_READY  out  1  result stream from the datapath.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, DP_PUSH, DP_PULL, WR_REQ, ADVANCE, FIN.
- Start condition: a START rising edge (registered previous value) while in IDLE.
  - START held high from before reset does not start a run.
- Latched at start: SRC_BASE and DST_BASE. SIZE and NUM are sampled continuously; software must not change them while BUSY.
- Counters, all cleared at start:
  - word_cnt (19b)
  - job_cnt (11b)
  - byte offset off (32b, modulo 2^32).
- Start with SIZE==0 or NUM==0: go directly to FIN. No bus traffic.
- RD_REQ
  - Drives AVM_READ=1 and AVM_ADDRESS=src_base+off.
  - Holds both until AVM_WAITREQUEST=0, then goes to RD_WAIT.
- RD_WAIT: captures AVM_READDATA into the operand register on AVM_READDATAVALID, then goes to DP_PUSH. Only one read is outstanding at a time.
- DP_PUSH: DP_IN_VALID=1 with the operand. Goes to DP_PULL on DP_IN_READY.
- DP_PULL: DP_OUT_READY=1. Captures DP_OUT_DATA on DP_OUT_VALID, then goes to WR_REQ.
- WR_REQ
  - Drives AVM_WRITE=1, AVM_ADDRESS=dst_base+off and AVM_WRITEDATA=result.
  - Holds all three until AVM_WAITREQUEST=0, then goes to ADVANCE.
- ADVANCE
  - Always: off += 4.
  - If word_cnt==SIZE-1: word_cnt=0 and job_cnt++.
    - If that was the last job (job_cnt==NUM-1): go to FIN.
    - Otherwise: go to RD_REQ.
  - Otherwise: word_cnt++ and go to RD_REQ.
- Jobs are contiguous in memory. Job j, word w is at base + 4*(j*SIZE + w), wrapping modulo 2^32.
- FIN: DONE=1. Stays in FIN until START==0, then goes to IDLE with DONE=0.
- START falling during a run is ignored; the run completes.
- Reset mid-run: abandons the transfer immediately. Strobes drop the next cycle and the block returns to IDLE. The datapath must be reset alongside it.
- BUSY=1 in every state except IDLE and FIN.
- JOB_IDX=job_cnt.
- Strobes are only ever asserted in their own state; AVM_READ and AVM_WRITE are never both high.

## Timing
- Reset values: every output is 0, including DONE, BUSY, JOB_IDX, AVM_*, DP_IN_VALID and DP_OUT_READY. State is IDLE.
- All outputs come from registers or are decoded from the state register only. There is no combinational path from any input to any output.
- Start latency: RD_REQ is entered (AVM_READ high) on the cycle after the START edge is registered, i.e. 2 clocks after START rises.
- Best case per word is 6 cycles, under these conditions:
  - zero waitrequest;
  - readdatavalid one cycle after the read is accepted;
  - DP_IN_READY=1;
  - DP_OUT_VALID on the cycle after the push.
- Each stall cycle on waitrequest, readdatavalid, ready or valid adds exactly one cycle.
- DONE rises one cycle after the ADVANCE of the final word. DONE falls one cycle after START is observed low.

## Test plan
- SIZE=4, NUM=1, SRC=0x1000, DST=0x2000, datapath returns x+1, memory src[i]=i, zero stalls.
  - Expected: reads at 0x1000..0x100C, writes of 1..4 at 0x2000..0x200C.
  - DONE rises 2+4*6 cycles after START.
- SIZE=3, NUM=2.
  - Expected: 6 sequential addresses, JOB_IDX goes 0 then 1, with the job switch after the 3rd write.
- Random AVM_WAITREQUEST, delayed READDATAVALID, random DP_IN_READY and DP_OUT_VALID.
  - Expected: address and data are stable while stalled, results are identical to the zero-stall run, and reads and writes never overlap.
- SIZE=0, NUM=5, then SIZE=5, NUM=0.
  - Expected: no AVM strobes; DONE is asserted 2 cycles after START.
- START held high across completion.
  - Expected: DONE stays 1.
  - START low: DONE returns to 0.
  - START high again: a second, identical run executes.
- Reset asserted during WR_REQ under a stall.
  - Expected: AVM_WRITE=0 and all outputs 0 on the next cycle. The block stays IDLE until a fresh START edge.

Source files
------------

// File: rtl/accel_job_sequencer_if.sv
// Avalon-MM master and datapath valid/ready streams used by the job sequencer.
// The master modport is the sequencer side; slave is the memory/datapath side.
interface accel_job_sequencer_if;
  logic [31:0] AVM_ADDRESS;
  logic        AVM_READ;
  logic        AVM_WRITE;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;
  logic [31:0] AVM_READDATA;
  logic        AVM_READDATAVALID;
  logic [31:0] DP_IN_DATA;
  logic        DP_IN_VALID;
  logic        DP_IN_READY;
  logic [31:0] DP_OUT_DATA;
  logic        DP_OUT_VALID;
  logic        DP_OUT_READY;

  modport master (
    output AVM_ADDRESS, AVM_READ, AVM_WRITE, AVM_WRITEDATA,
    input  AVM_WAITREQUEST, AVM_READDATA, AVM_READDATAVALID,
    output DP_IN_DATA, DP_IN_VALID, DP_OUT_READY,
    input  DP_IN_READY, DP_OUT_DATA, DP_OUT_VALID
  );

  modport slave (
    input  AVM_ADDRESS, AVM_READ, AVM_WRITE, AVM_WRITEDATA,
    output AVM_WAITREQUEST, AVM_READDATA, AVM_READDATAVALID,
    input  DP_IN_DATA, DP_IN_VALID, DP_OUT_READY,
    output DP_IN_READY, DP_OUT_DATA, DP_OUT_VALID
  );
endinterface

// File: rtl/accel_job_sequencer.sv
// Runs NUM jobs of SIZE words: read source word, push through datapath, write result.
// Every output is a register loaded from the next-state decode, so no input reaches an output combinationally.
module accel_job_sequencer (
  input  logic        CSI_CLOCK_CLK,
  input  logic        CSI_CLOCK_RESET,
  input  logic        START,
  input  logic [18:0] SIZE,
  input  logic [10:0] NUM,
  input  logic [31:0] SRC_BASE,
  input  logic [31:0] DST_BASE,
  output logic        DONE,
  output logic        BUSY,
  output logic [10:0] JOB_IDX,
  accel_job_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, DP_PUSH, DP_PULL, WR_REQ, ADVANCE, FIN
  } state_t;

  state_t      state_q, state_d;
  logic [18:0] wordCnt_q, wordCnt_d;
  logic [10:0] jobCnt_q, jobCnt_d;
  logic [31:0] off_q, off_d;
  logic [31:0] srcBase_q, srcBase_d;
  logic [31:0] dstBase_q, dstBase_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] result_q, result_d;
  logic [31:0] addr_q, addr_d;
  logic        startPrev_q, startEdge_q;
  logic        read_q, write_q, inValid_q, outReady_q, done_q, busy_q;

  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    jobCnt_d  = jobCnt_q;
    off_d     = off_q;
    srcBase_d = srcBase_q;
    dstBase_d = dstBase_q;
    operand_d = operand_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (startEdge_q) begin
          wordCnt_d = '0;
          jobCnt_d  = '0;
          off_d     = '0;
          srcBase_d = SRC_BASE;
          dstBase_d = DST_BASE;
          state_d   = (SIZE == 19'd0 || NUM == 11'd0) ? FIN : RD_REQ;
        end
      end
      RD_REQ:  if (!bus.AVM_WAITREQUEST) state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.AVM_READDATAVALID) begin
          operand_d = bus.AVM_READDATA;
          state_d   = DP_PUSH;
        end
      end
      DP_PUSH: if (bus.DP_IN_READY) state_d = DP_PULL;
      DP_PULL: begin
        if (bus.DP_OUT_VALID) begin
          result_d = bus.DP_OUT_DATA;
          state_d  = WR_REQ;
        end
      end
      WR_REQ:  if (!bus.AVM_WAITREQUEST) state_d = ADVANCE;
      ADVANCE: begin
        off_d = off_q + 32'd4;
        if (wordCnt_q == SIZE - 19'd1) begin
          wordCnt_d = '0;
          jobCnt_d  = jobCnt_q + 11'd1;
          state_d   = (jobCnt_q == NUM - 11'd1) ? FIN : RD_REQ;
        end else begin
          wordCnt_d = wordCnt_q + 19'd1;
          state_d   = RD_REQ;
        end
      end
      FIN:     if (!START) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address is a pure function of the next state so it stays stable through stalls.
  always_comb begin
    addr_d = '0;
    if (state_d == RD_REQ)      addr_d = srcBase_d + off_d;
    else if (state_d == WR_REQ) addr_d = dstBase_d + off_d;
  end

  // A level already high when reset releases must not look like an edge, hence startPrev_q tracks START in reset.
  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (CSI_CLOCK_RESET) begin
      state_q     <= IDLE;
      wordCnt_q   <= '0;
      jobCnt_q    <= '0;
      off_q       <= '0;
      srcBase_q   <= '0;
      dstBase_q   <= '0;
      operand_q   <= '0;
      result_q    <= '0;
      addr_q      <= '0;
      startPrev_q <= START;
      startEdge_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      inValid_q   <= 1'b0;
      outReady_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordCnt_q   <= wordCnt_d;
      jobCnt_q    <= jobCnt_d;
      off_q       <= off_d;
      srcBase_q   <= srcBase_d;
      dstBase_q   <= dstBase_d;
      operand_q   <= operand_d;
      result_q    <= result_d;
      addr_q      <= addr_d;
      startPrev_q <= START;
      startEdge_q <= START & ~startPrev_q;
      read_q      <= (state_d == RD_REQ);
      write_q     <= (state_d == WR_REQ);
      inValid_q   <= (state_d == DP_PUSH);
      outReady_q  <= (state_d == DP_PULL);
      done_q      <= (state_d == FIN);
      busy_q      <= (state_d != IDLE) && (state_d != FIN);
    end
  end

  assign bus.AVM_ADDRESS   = addr_q;
  assign bus.AVM_READ      = read_q;
  assign bus.AVM_WRITE     = write_q;
  assign bus.AVM_WRITEDATA = result_q;
  assign bus.DP_IN_DATA    = operand_q;
  assign bus.DP_IN_VALID   = inValid_q;
  assign bus.DP_OUT_READY  = outReady_q;
  assign DONE              = done_q;
  assign BUSY              = busy_q;
  assign JOB_IDX           = jobCnt_q;

endmodule
